// File: rtl/calc_pkg.sv
// Shared encodings for the calculator arithmetic core: operation codes and FSM states.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ITER = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/calc_iter_unit.sv
// Shift-add multiplier / restoring divider on one 2*WIDTH accumulator, one bit per step.
// Latency WIDTH steps after load; no backpressure, the parent FSM paces load/step.
module calc_iter_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic                 step,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc
);

  logic             mode_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] acc_n;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    div_rem   = {acc[2*WIDTH-1:WIDTH-1]};
    div_trial = div_rem - {1'b0, b_q};
    acc_n     = acc;
    if (!mode_q) begin
      // multiply: conditionally add into the high half, then shift the whole product right
      if (acc[0])
        acc_n = {mul_sum, acc[WIDTH-1:1]};
      else
        acc_n = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
    end else begin
      // divide: {remainder, dividend/quotient} shifts left; trial subtract sets the quotient bit
      if (!div_trial[WIDTH])
        acc_n = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_n = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      mode_q <= mode;
      b_q    <= b;
      acc    <= {{WIDTH{1'b0}}, a};
    end else if (step) begin
      acc    <= acc_n;
    end
  end

endmodule

// File: rtl/param_calc_core.sv
// Four-function unsigned calculator core with start/busy/done handshake.
// Latency 1 cycle add/sub/div-by-zero, WIDTH+1 mul/div; start ignored unless IDLE.
module param_calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ovf,
  output logic                 neg,
  output logic                 dz
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state, state_n;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CW-1:0]      cnt;
  logic               accept, iterative, load, step;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk  (clk),
    .load (load),
    .step (step),
    .mode (op == OP_DIV),
    .a    (a),
    .b    (b),
    .acc  (acc)
  );

  always_comb begin
    accept    = (state == IDLE) && start;
    iterative = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    load      = accept && iterative;
    step      = (state == ITER);
    busy      = (state == CALC) || (state == ITER);
    done      = (state == FIN);
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = a_q - b_q;
    state_n   = state;
    case (state)
      IDLE: if (start) state_n = iterative ? ITER : CALC;
      CALC: state_n = FIN;
      ITER: if (cnt == CW'(1)) state_n = CALC;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      neg    <= 1'b0;
      dz     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
        cnt  <= CW'(WIDTH);
      end else if (step) begin
        cnt  <= cnt - CW'(1);
      end
      if (state == CALC) begin
        ovf <= 1'b0;
        neg <= 1'b0;
        dz  <= 1'b0;
        case (op_q)
          OP_ADD: begin
            result <= {{(WIDTH-1){1'b0}}, sum};
            ovf    <= sum[WIDTH];
          end
          OP_SUB: begin
            result <= {{WIDTH{1'b0}}, diff};
            neg    <= (a_q < b_q);
          end
          OP_MUL: begin
            result <= acc;
            ovf    <= |acc[2*WIDTH-1:WIDTH];
          end
          default: begin
            if (b_q == '0) begin
              result <= {a_q, {WIDTH{1'b1}}};
              dz     <= 1'b1;
            end else begin
              result <= acc;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_calc_core.sv
// Scoreboard bench for param_calc_core at WIDTH=8 and WIDTH=4 with directed vectors.
module tb_param_calc_core;
  import calc_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        neg;
    logic        dz;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start8 = 1'b0, start4 = 1'b0;
  logic [1:0]  op8 = OP_ADD, op4 = OP_ADD;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy8, done8, ovf8, neg8, dz8;
  logic        busy4, done4, ovf4, neg4, dz4;
  logic [15:0] result8;
  logic [7:0]  result4;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q8[$];
  exp_t q4[$];
  exp_t m8, m4;

  param_calc_core #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .ovf(ovf8), .neg(neg8), .dz(dz8)
  );

  param_calc_core #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .ovf(ovf4), .neg(neg4), .dz(dz4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("spurious_done8", 1, 0);
      else begin
        m8 = q8.pop_front();
        chk("result8", 32'(result8), 32'(m8.res));
        chk("ovf8", 32'(ovf8), 32'(m8.ovf));
        chk("neg8", 32'(neg8), 32'(m8.neg));
        chk("dz8", 32'(dz8), 32'(m8.dz));
        chk("latency8", cyc - m8.acc_cyc, m8.lat);
      end
    end
    if (done4) begin
      if (q4.size() == 0) chk("spurious_done4", 1, 0);
      else begin
        m4 = q4.pop_front();
        chk("result4", 32'(result4), 32'(m4.res));
        chk("ovf4", 32'(ovf4), 32'(m4.ovf));
        chk("neg4", 32'(neg4), 32'(m4.neg));
        chk("dz4", 32'(dz4), 32'(m4.dz));
        chk("latency4", cyc - m4.acc_cyc, m4.lat);
      end
    end
  end

  task automatic issue(input bit w4, input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] er, input logic eo, input logic en, input logic ed,
                       input int lat, input int poke);
    exp_t e;
    bit   got;
    @(negedge clk);
    if (w4) begin start4 = 1'b1; op4 = o; a4 = av[3:0]; b4 = bv[3:0]; end
    else    begin start8 = 1'b1; op8 = o; a8 = av;      b8 = bv;      end
    @(posedge clk); #1;
    e.res = er; e.ovf = eo; e.neg = en; e.dz = ed; e.lat = lat; e.acc_cyc = cyc;
    if (w4) q4.push_back(e); else q8.push_back(e);
    chk("busy_after_accept", 32'(w4 ? busy4 : busy8), 1);
    @(negedge clk);
    start8 = 1'b0; start4 = 1'b0;
    a8 = ~a8; b8 = ~b8; a4 = ~a4; b4 = ~b4;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (poke != 0 && i == poke) begin
        start8 = 1'b1; op8 = OP_ADD; a8 = 8'd1; b8 = 8'd1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      if (w4 ? done4 : done8) got = 1'b1;
    end
    start8 = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_result", 32'(result8), 0);
    chk("rst_flags", {29'd0, ovf8, neg8, dz8}, 0);
    reset = 1'b0;

    issue(0, OP_ADD, 8'd200, 8'd100, 16'h012C, 1, 0, 0, 1, 0);
    issue(0, OP_SUB, 8'd5,   8'd9,   16'h00FC, 0, 1, 0, 1, 0);
    issue(0, OP_MUL, 8'd15,  8'd17,  16'h00FF, 0, 0, 0, 9, 0);
    issue(0, OP_MUL, 8'd200, 8'd3,   16'h0258, 1, 0, 0, 9, 3);
    issue(0, OP_DIV, 8'd100, 8'd7,   16'h020E, 0, 0, 0, 9, 0);
    issue(0, OP_ADD, 8'd255, 8'd255, 16'h01FE, 1, 0, 0, 1, 0);
    issue(0, OP_SUB, 8'd9,   8'd5,   16'h0004, 0, 0, 0, 1, 0);
    issue(0, OP_MUL, 8'd255, 8'd255, 16'hFE01, 1, 0, 0, 9, 0);
    issue(0, OP_DIV, 8'd255, 8'd1,   16'h00FF, 0, 0, 0, 9, 0);
    issue(0, OP_DIV, 8'd50,  8'd0,   16'h32FF, 0, 0, 1, 1, 0);
    repeat (3) @(negedge clk);
    chk("result_hold", 32'(result8), 32'h32FF);
    chk("dz_hold", 32'(dz8), 1);

    // reset four cycles into a multiply: no completion may follow
    @(negedge clk);
    start8 = 1'b1; op8 = OP_MUL; a8 = 8'd255; b8 = 8'd255;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_done", 32'(done8), 0);
    chk("abort_result", 32'(result8), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);

    issue(0, OP_ADD, 8'd1, 8'd1, 16'h0002, 0, 0, 0, 1, 0);

    issue(1, OP_MUL, 8'd15, 8'd15, 16'h00E1, 1, 0, 0, 5, 0);
    issue(1, OP_DIV, 8'd9,  8'd2,  16'h0014, 0, 0, 0, 5, 0);
    issue(1, OP_DIV, 8'd7,  8'd0,  16'h007F, 0, 0, 1, 1, 0);

    repeat (5) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
